// File: rtl/vga_pkg.sv
// Shared timing defaults, derived-constant helpers and the test-pattern
// bar colour table for the VGA timing generator.
package vga_pkg;

  // 640x480@60 defaults
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_CNT_W    = 10;

  function automatic int axis_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  // First count inside the sync pulse
  function automatic int sync_start(int act, int fp);
    return act + fp;
  endfunction

  // First count after the sync pulse
  function automatic int sync_end(int act, int fp, int sync);
    return act + fp + sync;
  endfunction

  // Bar k -> {red_on, green_on, blue_on}
  localparam logic [7:0][2:0] BAR_RGB = {3'b111, 3'b110, 3'b101, 3'b100,
                                         3'b011, 3'b010, 3'b001, 3'b000};

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrap counter: counts 0..TOTAL-1 while enabled, flags terminal count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int W     = DEF_CNT_W,
  parameter int TOTAL = 800
)(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] r_cnt;

  // Count on enable, wrap at the terminal value
  always_ff @(posedge i_clk) begin
    if (i_rst)             r_cnt <= '0;
    else if (i_en) begin
      if (r_cnt == LAST)   r_cnt <= '0;
      else                 r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock divider, H/V counters,
// sync decode and a colour/sync output register aligned one pixel behind
// the exported coordinates. Optional 8-bar test pattern behind the
// VGA_TESTPATTERN_EN macro (adds the tp_sel input).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2,
  parameter int CNT_W    = DEF_CNT_W
)(
  input  logic             Clock,
  input  logic             reset,
`ifdef VGA_TESTPATTERN_EN
  input  logic             tp_sel,
`endif
  input  logic [R_W-1:0]   rin,
  input  logic [G_W-1:0]   gin,
  input  logic [B_W-1:0]   bin,
  output logic [CNT_W-1:0] Posx,
  output logic [CNT_W-1:0] Posy,
  output logic             pix_ce,
  output logic             active,
  output logic             frame_start,
  output logic [7:0]       frame_cnt,
  output logic [R_W-1:0]   Rojo,
  output logic [G_W-1:0]   Verde,
  output logic [B_W-1:0]   Azul,
  output logic             Hsinc,
  output logic             Vsinc
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_FIN   = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_FIN   = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic [DIV_W-1:0] r_div;
  logic             w_pix_ce;
  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic             w_h_tc;
  logic             w_v_tc;
  logic             w_line_carry;
  logic             w_frame_wrap;
  logic             w_active;
  logic             w_hs_dec;
  logic             w_vs_dec;
  logic [R_W-1:0]   w_r_src;
  logic [G_W-1:0]   w_g_src;
  logic [B_W-1:0]   w_b_src;
  logic [R_W-1:0]   r_red;
  logic [G_W-1:0]   r_grn;
  logic [B_W-1:0]   r_blu;
  logic             r_hs;
  logic             r_vs;
  logic             r_fs;
  logic [7:0]       r_fcnt;

  // System-clock divider; the strobe is masked while reset is held so that
  // CLK_DIV=1 still shows pix_ce=0 during reset
  always_ff @(posedge Clock) begin
    if (reset)                  r_div <= '0;
    else if (r_div == DIV_LAST) r_div <= '0;
    else                        r_div <= r_div + 1'b1;
  end

  assign w_pix_ce     = (r_div == DIV_LAST) & ~reset;
  assign w_line_carry = w_pix_ce & w_h_tc;
  assign w_frame_wrap = w_line_carry & w_v_tc;

  vga_axis_counter #(.W(CNT_W), .TOTAL(H_TOTAL)) u_hcnt (
    .i_clk (Clock),
    .i_rst (reset),
    .i_en  (w_pix_ce),
    .o_cnt (w_hcnt),
    .o_tc  (w_h_tc)
  );

  vga_axis_counter #(.W(CNT_W), .TOTAL(V_TOTAL)) u_vcnt (
    .i_clk (Clock),
    .i_rst (reset),
    .i_en  (w_line_carry),
    .o_cnt (w_vcnt),
    .o_tc  (w_v_tc)
  );

  assign w_active = (w_hcnt < H_ACT_C) && (w_vcnt < V_ACT_C);
  assign w_hs_dec = ((w_hcnt >= HS_BEG) && (w_hcnt < HS_FIN)) ? HS_POL : ~HS_POL;
  assign w_vs_dec = ((w_vcnt >= VS_BEG) && (w_vcnt < VS_FIN)) ? VS_POL : ~VS_POL;

`ifdef VGA_TESTPATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] w_bar;

  // Bar index from the horizontal position (compare chain, no divider)
  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++)
      if (w_hcnt >= CNT_W'(k * BAR_W)) w_bar = 3'(k);
  end

  assign w_r_src = tp_sel ? {R_W{BAR_RGB[w_bar][2]}} : rin;
  assign w_g_src = tp_sel ? {G_W{BAR_RGB[w_bar][1]}} : gin;
  assign w_b_src = tp_sel ? {B_W{BAR_RGB[w_bar][0]}} : bin;
`else
  assign w_r_src = rin;
  assign w_g_src = gin;
  assign w_b_src = bin;
`endif

  // Register colour and sync of the departing pixel together so they stay
  // aligned one pixel behind Posx/Posy; blank outside the active window
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_red <= '0;
      r_grn <= '0;
      r_blu <= '0;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
    end else if (w_pix_ce) begin
      r_red <= w_active ? w_r_src : '0;
      r_grn <= w_active ? w_g_src : '0;
      r_blu <= w_active ? w_b_src : '0;
      r_hs  <= w_hs_dec;
      r_vs  <= w_vs_dec;
    end
  end

  // Frame pulse coincides with the edge that loads (0,0); count frames
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_fs   <= 1'b0;
      r_fcnt <= '0;
    end else begin
      r_fs <= w_frame_wrap;
      if (w_frame_wrap) r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign Posx        = w_hcnt;
  assign Posy        = w_vcnt;
  assign pix_ce      = w_pix_ce;
  assign active      = w_active;
  assign frame_start = r_fs;
  assign frame_cnt   = r_fcnt;
  assign Rojo        = r_red;
  assign Verde       = r_grn;
  assign Azul        = r_blu;
  assign Hsinc       = r_hs;
  assign Vsinc       = r_vs;

endmodule
